// File: rtl/mac_pkg.sv
// Shared types and constants for the RMII transmit MAC and its CRC engine.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    SRC,
    PAD,
    FCS,
    IPG
  } state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT   = 2'b01;
  localparam logic [1:0]  SFD_DIBIT        = 2'b11;
  localparam logic [31:0] CRC_INIT         = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY         = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE      = 32'hC704_DD7B;
  localparam logic [5:0]  PREAMBLE_DIBITS  = 6'd31;
  localparam logic [15:0] MIN_FRAME_DIBITS = 16'd240;
  localparam logic [5:0]  IPG_DIBITS       = 6'd48;
  localparam logic [5:0]  FCS_DIBITS       = 6'd16;
  localparam logic [5:0]  SRC_DIBITS       = 6'd24;
  localparam logic [15:0] SRC_START_DIBITS = 16'd24;
  localparam logic [47:0] THIS_MAC         = 48'hb8_27_eb_a4_30_73;

  // Dibit idx of THIS_MAC in wire order: first byte (0xb8) first, LSB dibit first.
  function automatic logic [1:0] src_dibit(input logic [4:0] idx);
    logic [7:0] mac_byte;
    mac_byte = 8'(THIS_MAC >> (8 * (5 - int'(idx[4:2]))));
    return 2'(mac_byte >> (2 * int'(idx[1:0])));
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Reflected CRC-32 (Ethernet FCS) advancing one RMII dibit per clock, d[0] first.
module crc32_dibit
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        calc,
  input  logic [1:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_bit0;
  logic [31:0] crc_bit1;

  always_comb begin
    crc_bit0 = {1'b0, crc[31:1]}      ^ ((crc[0]      ^ d[0]) ? CRC_POLY : 32'h0);
    crc_bit1 = {1'b0, crc_bit0[31:1]} ^ ((crc_bit0[0] ^ d[1]) ? CRC_POLY : 32'h0);
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (calc) begin
      crc <= crc_bit1;
    end
  end

endmodule

// File: rtl/mac_tx.sv
// RMII transmit MAC: preamble/SFD, min-length padding, FCS and inter-packet gap.
// Define MAC_TX_SRC_INSERT_EN to have the block insert THIS_MAC as the source address.
module mac_tx
  import mac_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       axi_tx_valid,
  input  logic [1:0] axi_tx_data,
  input  logic       axi_tx_last,
  output logic       axi_tx_ready,
  output logic       phy_txen,
  output logic [1:0] phy_txd,
  output logic       tx_err
);

  state_t      state_q, state_d;
  logic [5:0]  phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic        underflow_q, underflow_d;
  logic        txen_d, err_d;
  logic [1:0]  txd_d;
  logic        crc_init, crc_calc;
  logic [1:0]  crc_din;
  logic [31:0] crc;
  logic [31:0] fcs_word;
  logic [15:0] cnt_inc;
  logic        frame_ok;

  crc32_dibit u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (crc_init),
    .calc  (crc_calc),
    .d     (crc_din),
    .crc   (crc)
  );

  assign cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign frame_ok     = (cnt_inc >= MIN_FRAME_DIBITS) && (cnt_inc[1:0] == 2'b00);
  // An underflowed frame sends the true CRC, i.e. the complement of a valid FCS.
  assign fcs_word     = underflow_q ? crc : ~crc;
  assign axi_tx_ready = (state_q == DATA);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    txen_d      = 1'b0;
    txd_d       = 2'b00;
    err_d       = 1'b0;
    crc_init    = 1'b0;
    crc_calc    = 1'b0;
    crc_din     = 2'b00;

    case (state_q)
      IDLE: begin
        underflow_d = 1'b0;
        cnt_d       = 16'd0;
        phase_d     = 6'd0;
        if (axi_tx_valid) begin
          txen_d  = 1'b1;
          txd_d   = PREAMBLE_DIBIT;
          phase_d = 6'd1;
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        txen_d  = 1'b1;
        txd_d   = PREAMBLE_DIBIT;
        phase_d = phase_q + 6'd1;
        if (phase_q == PREAMBLE_DIBITS - 6'd1) state_d = SFD;
      end
      SFD: begin
        txen_d   = 1'b1;
        txd_d    = SFD_DIBIT;
        crc_init = 1'b1;
        phase_d  = 6'd0;
        state_d  = DATA;
      end
      DATA: begin
        txen_d   = 1'b1;
        crc_calc = 1'b1;
        cnt_d    = cnt_inc;
        if (axi_tx_valid) begin
          txd_d   = axi_tx_data;
          crc_din = axi_tx_data;
          if (axi_tx_last) begin
            phase_d = 6'd0;
            state_d = frame_ok ? FCS : PAD;
          end
`ifdef MAC_TX_SRC_INSERT_EN
          else if (cnt_inc == SRC_START_DIBITS) begin
            phase_d = 6'd0;
            state_d = SRC;
          end
`endif
        end else begin
          underflow_d = 1'b1;
        end
      end
`ifdef MAC_TX_SRC_INSERT_EN
      SRC: begin
        txen_d   = 1'b1;
        txd_d    = src_dibit(phase_q[4:0]);
        crc_din  = txd_d;
        crc_calc = 1'b1;
        cnt_d    = cnt_inc;
        phase_d  = phase_q + 6'd1;
        if (phase_q == SRC_DIBITS - 6'd1) state_d = DATA;
      end
`endif
      PAD: begin
        txen_d   = 1'b1;
        crc_calc = 1'b1;
        cnt_d    = cnt_inc;
        if (frame_ok) begin
          phase_d = 6'd0;
          state_d = FCS;
        end
      end
      FCS: begin
        txen_d  = 1'b1;
        txd_d   = fcs_word[{phase_q[3:0], 1'b0} +: 2];
        phase_d = phase_q + 6'd1;
        if (phase_q == FCS_DIBITS - 6'd1) begin
          err_d   = underflow_q;
          phase_d = 6'd0;
          state_d = IPG;
        end
      end
      IPG: begin
        phase_d = phase_q + 6'd1;
        if (phase_q == IPG_DIBITS - 6'd1) begin
          phase_d = 6'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= 6'd0;
      cnt_q       <= 16'd0;
      underflow_q <= 1'b0;
      phy_txen    <= 1'b0;
      phy_txd     <= 2'b00;
      tx_err      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
      phy_txen    <= txen_d;
      phy_txd     <= txd_d;
      tx_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_mac_tx.sv
// Randomized bench for mac_tx: a frame-level reference model predicts every wire dibit.
module tb_mac_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       axi_tx_valid;
  logic [1:0] axi_tx_data;
  logic       axi_tx_last;
  logic       axi_tx_ready;
  logic       phy_txen;
  logic [1:0] phy_txd;
  logic       tx_err;

  always #10 clk = ~clk;

  mac_tx dut (
    .clk          (clk),
    .reset        (reset),
    .axi_tx_valid (axi_tx_valid),
    .axi_tx_data  (axi_tx_data),
    .axi_tx_last  (axi_tx_last),
    .axi_tx_ready (axi_tx_ready),
    .phy_txen     (phy_txen),
    .phy_txd      (phy_txd),
    .tx_err       (tx_err)
  );

  localparam logic [47:0] MAC_ADDR = 48'hb8_27_eb_a4_30_73;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected wire streams, flattened, with per-frame length and error flag.
  logic [1:0] exp_flat[$];
  int         exp_len[$];
  bit         exp_err[$];

  logic [1:0] cur[$];
  bit         in_frame    = 1'b0;
  int         low_cnt     = 0;
  int         gaps[$];
  int         err_pulses  = 0;
  int         ready_viol  = 0;
  int         frames_done = 0;

  // Bit-serial reflected CRC-32 over a dibit stream, each dibit LSB first.
  function automatic logic [31:0] crc_stream(input logic [1:0] q[$], input int from);
    logic [31:0] c;
    bit          b;
    c = 32'hFFFF_FFFF;
    for (int i = from; i < q.size(); i++) begin
      for (int k = 0; k < 2; k++) begin
        b = q[i][k];
        c = (c >> 1) ^ ((c[0] ^ b) ? 32'hEDB8_8320 : 32'h0);
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] bit_reverse(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic model_frame(input logic [1:0] up[$], input int gap_at, input int gap_len);
    logic [1:0]  body[$];
    logic [31:0] fcs;
    logic [7:0]  b;
    for (int i = 0; i < up.size(); i++) begin
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) body.push_back(2'b00);
      body.push_back(up[i]);
`ifdef MAC_TX_SRC_INSERT_EN
      if (i == 23)
        for (int k = 0; k < 6; k++) begin
          b = 8'(MAC_ADDR >> (40 - 8 * k));
          for (int j = 0; j < 4; j++) body.push_back(2'(b >> (2 * j)));
        end
`endif
    end
    while (body.size() < 240 || (body.size() % 4) != 0) body.push_back(2'b00);
    fcs = ~crc_stream(body, 0);
    if (gap_len > 0) fcs = ~fcs;
    for (int i = 0; i < 31; i++) exp_flat.push_back(2'b01);
    exp_flat.push_back(2'b11);
    foreach (body[i]) exp_flat.push_back(body[i]);
    for (int i = 0; i < 16; i++) exp_flat.push_back(2'(fcs >> (2 * i)));
    exp_len.push_back(32 + body.size() + 16);
    exp_err.push_back(gap_len > 0);
  endtask

  task automatic finish_frame();
    int          n;
    int          mism;
    logic [1:0]  e;
    bit          e_err;
    logic [31:0] c;
    if (exp_len.size() == 0) begin
      check("unexpected_frame", cur.size(), 0);
      cur.delete();
      return;
    end
    n    = exp_len.pop_front();
    mism = 0;
    check("frame_len", cur.size(), n);
    for (int i = 0; i < n; i++) begin
      e = exp_flat.pop_front();
      if (i >= cur.size() || cur[i] !== e) mism++;
    end
    check("frame_dibits_mismatched", mism, 0);
    c     = crc_stream(cur, 32);
    e_err = exp_err.pop_front();
    check("rx_fcs_good", bit_reverse(c) == 32'hC704_DD7B, !e_err);
    check("tx_err_pulses", err_pulses, e_err);
    err_pulses = 0;
    cur.delete();
    frames_done++;
  endtask

  // Wire monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      cur.delete();
      in_frame   = 1'b0;
      low_cnt    = 0;
      err_pulses = 0;
    end else begin
      if (axi_tx_ready && !phy_txen) ready_viol++;
      if (tx_err) err_pulses++;
      if (phy_txen) begin
        if (!in_frame) begin
          gaps.push_back(low_cnt);
          in_frame = 1'b1;
        end
        cur.push_back(phy_txd);
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          low_cnt  = 0;
          finish_frame();
        end
        low_cnt++;
      end
    end
  end

  task automatic send(input int n, input int gap_at, input int gap_len, input int abort_at);
    logic [1:0] up[$];
    int         i;
    int         g;
    int         budget;
    logic       r;
    for (int k = 0; k < n; k++) up.push_back(2'($urandom));
    if (abort_at < 0) model_frame(up, gap_at, gap_len);
    i = 0; g = 0; budget = 0;
    while (i < n) begin
      if (i == gap_at && g < gap_len) begin
        axi_tx_valid = 1'b0;
        axi_tx_last  = 1'b0;
      end else begin
        axi_tx_valid = 1'b1;
        axi_tx_data  = up[i];
        axi_tx_last  = (i == n - 1);
      end
      @(negedge clk);
      r = axi_tx_ready;
      @(posedge clk);
      #1;
      if (r) begin
        if (axi_tx_valid) i++;
        else g++;
      end
      if (i == abort_at) begin
        #3 reset = 1'b1;
        #1 check("reset_drops_txen", phy_txen, 1'b0);
        axi_tx_valid = 1'b0;
        axi_tx_last  = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        return;
      end
      budget++;
      if (budget > 4000) begin
        check("send_timeout", i, n);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    axi_tx_valid = 1'b0;
    axi_tx_last  = 1'b0;
    while ((exp_len.size() != 0 || phy_txen) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check("frame_drained", exp_len.size(), 0);
    repeat (60) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int gap_at;
    int gap_len;
    reset        = 1'b1;
    axi_tx_valid = 1'b0;
    axi_tx_data  = 2'b00;
    axi_tx_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txen", phy_txen, 1'b0);
    check("reset_txd", phy_txd, 2'b00);
    check("reset_err", tx_err, 1'b0);
    check("reset_ready", axi_tx_ready, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(240, -1, 0, -1);          // exactly minimum length
    wait_idle();
    send(56, -1, 0, -1);           // short frame, padded
    wait_idle();
    send(200, -1, 0, -1);          // back-to-back with valid held high
    send(150, -1, 0, -1);
    wait_idle();
    check("ipg_len", gaps[gaps.size() - 1], 48);
    send(200, 150, 3, -1);         // mid-frame underflow
    wait_idle();
    send(300, -1, 0, 100);         // reset mid-payload
    repeat (3) @(posedge clk);
    #1;
    send(80, -1, 0, -1);
    wait_idle();

    for (int f = 0; f < 5; f++) begin
      n       = $urandom_range(400, 30);
      gap_at  = -1;
      gap_len = 0;
      if ($urandom_range(1, 0) == 1) begin
        gap_at  = $urandom_range(n - 1, 30);
        gap_len = $urandom_range(5, 1);
      end
      send(n, gap_at, gap_len, -1);
      wait_idle();
    end

    check("ready_only_while_sending", ready_viol, 0);
    check("frames_seen", frames_done, 11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
